// File: rtl/aes_inv_pkg.sv
// Shared types and GF(2^8) helpers for the word-serial AES inverse round engine.
// State byte 0 sits in bits [127:120]; bytes are column-major as in FIPS-197.
package aes_inv_pkg;

   localparam int AES_STATE_W = 128;
   localparam int AES_WORD_W  = 32;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SUB  = 2'd1,
      MIX  = 2'd2,
      HOLD = 2'd3
   } fsm_state_e;

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] acc;
      logic [7:0] p;
      acc = '0;
      p   = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) acc = acc ^ p;
         p = xtime(p);
      end
      return acc;
   endfunction

   // Row r moves right by r columns: out[r][c] = in[r][(c - r) mod 4].
   function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
      logic [127:0] r;
      r = '0;
      for (int c = 0; c < 4; c++)
         for (int row = 0; row < 4; row++)
            r[127 - 8*(4*c + row) -: 8] = s[127 - 8*(4*((c - row + 4) % 4) + row) -: 8];
      return r;
   endfunction

   function automatic logic [31:0] inv_mix_col(input logic [31:0] w);
      logic [7:0] a0, a1, a2, a3;
      a0 = w[31:24];
      a1 = w[23:16];
      a2 = w[15:8];
      a3 = w[7:0];
      return {gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09),
              gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d),
              gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b),
              gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e)};
   endfunction

endpackage

// File: rtl/aes_inv_sbox.sv
// Combinational AES inverse S-box applied to each byte of a 32-bit word.
module aes_inv_sbox (
   input  logic [31:0] i_inv_wrd_sbox,
   output logic [31:0] o_inv_wrd_sbox
);

   // Entry 0 occupies the top byte, so entry b lives at bits [2047-8b -: 8].
   localparam logic [2047:0] INV_SBOX_TAB = {
      128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
      128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
      128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
      128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
      128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
      128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
      128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
      128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
   };

   for (genvar gi = 0; gi < 4; gi++) begin : g_byte
      logic [7:0]  b_in;
      logic [10:0] tab_idx;
      assign b_in    = i_inv_wrd_sbox[8*gi +: 8];
      assign tab_idx = 11'd2047 - {b_in, 3'b000};
      assign o_inv_wrd_sbox[8*gi +: 8] = INV_SBOX_TAB[tab_idx -: 8];
   end

endmodule

// File: rtl/aes_inv_round_seq.sv
// Word-serial AES inverse round: InvShiftRows, InvSubBytes one column per cycle,
// AddRoundKey and InvMixColumns. Option macro: AES_INV_LAST_ROUND_EN adds i_last.
module aes_inv_round_seq
   import aes_inv_pkg::*;
#(
   parameter int WORD_W  = AES_WORD_W,
   parameter int STATE_W = AES_STATE_W
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic               i_valid,
   output logic               o_ready,
   input  logic [STATE_W-1:0] i_state,
   input  logic [STATE_W-1:0] i_round_key,
`ifdef AES_INV_LAST_ROUND_EN
   input  logic               i_last,
`endif
   output logic               o_valid,
   input  logic               i_ready,
   output logic [STATE_W-1:0] o_state
);

   fsm_state_e         fsm_reg;
   logic [1:0]         col_reg;
   logic [STATE_W-1:0] state_reg;
   logic [STATE_W-1:0] key_reg;
   logic [STATE_W-1:0] out_reg;
`ifdef AES_INV_LAST_ROUND_EN
   logic               last_reg;
`endif

   logic [WORD_W-1:0]  col_word [4];
   logic [WORD_W-1:0]  sbox_in;
   logic [WORD_W-1:0]  sbox_out;
   logic [STATE_W-1:0] sub_state;
   logic [STATE_W-1:0] add_state;
   logic [STATE_W-1:0] mix_state;
   logic [STATE_W-1:0] round_out;

   // The single S-box is shared across columns; col_reg picks which one it sees.
   assign sbox_in   = col_word[col_reg];
   assign add_state = state_reg ^ key_reg;

   aes_inv_sbox u_sbox (
      .i_inv_wrd_sbox (sbox_in),
      .o_inv_wrd_sbox (sbox_out)
   );

   for (genvar gi = 0; gi < 4; gi++) begin : g_col
      assign col_word[gi] = state_reg[STATE_W-1-WORD_W*gi -: WORD_W];
      assign sub_state[STATE_W-1-WORD_W*gi -: WORD_W] =
         (col_reg == 2'(gi)) ? sbox_out : col_word[gi];
      assign mix_state[STATE_W-1-WORD_W*gi -: WORD_W] =
         inv_mix_col(add_state[STATE_W-1-WORD_W*gi -: WORD_W]);
   end

`ifdef AES_INV_LAST_ROUND_EN
   assign round_out = last_reg ? add_state : mix_state;
`else
   assign round_out = mix_state;
`endif

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         fsm_reg   <= IDLE;
         col_reg   <= '0;
         state_reg <= '0;
         key_reg   <= '0;
         out_reg   <= '0;
`ifdef AES_INV_LAST_ROUND_EN
         last_reg  <= 1'b0;
`endif
      end else begin
         case (fsm_reg)
            IDLE: if (i_valid) begin
               state_reg <= inv_shift_rows(i_state);
               key_reg   <= i_round_key;
`ifdef AES_INV_LAST_ROUND_EN
               last_reg  <= i_last;
`endif
               col_reg   <= '0;
               fsm_reg   <= SUB;
            end
            SUB: begin
               state_reg <= sub_state;
               col_reg   <= col_reg + 2'd1;
               if (col_reg == 2'd3) fsm_reg <= MIX;
            end
            MIX: begin
               out_reg <= round_out;
               fsm_reg <= HOLD;
            end
            HOLD: if (i_ready) fsm_reg <= IDLE;
            default: fsm_reg <= IDLE;
         endcase
      end
   end

   assign o_ready = (fsm_reg == IDLE);
   assign o_valid = (fsm_reg == HOLD);
   assign o_state = out_reg;

endmodule

// File: tb/tb_aes_inv_round_seq.sv
// Bench for aes_inv_round_seq: byte-level reference model with a derived
// inverse S-box, per-cycle output monitor and directed FIPS-197 vectors.
module tb_aes_inv_round_seq;

   localparam logic [127:0] C1_STATE = 128'h7ad5fda789ef4e272bca100b3d9ff59f;
   localparam logic [127:0] C1_KEY   = 128'h549932d1f08557681093ed9cbe2c974e;
   localparam logic [127:0] C1_MIX   = 128'h54d990a16ba09ab596bbf40ea111702f;
   localparam logic [127:0] C1_LAST  = 128'he9f74eec023020f61bf2ccf2353c21c7;
   localparam logic [127:0] ALL_52   = {16{8'h52}};

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         i_valid = 1'b0;
   logic         o_ready;
   logic [127:0] i_state = '0;
   logic [127:0] i_round_key = '0;
`ifdef AES_INV_LAST_ROUND_EN
   logic         tb_last = 1'b0;
`endif
   logic         o_valid;
   logic         i_ready = 1'b1;
   logic [127:0] o_state;

   always #5 clk = ~clk;

   aes_inv_round_seq dut (
      .i_clk       (clk),
      .i_rst       (rst),
      .i_valid     (i_valid),
      .o_ready     (o_ready),
      .i_state     (i_state),
      .i_round_key (i_round_key),
`ifdef AES_INV_LAST_ROUND_EN
      .i_last      (tb_last),
`endif
      .o_valid     (o_valid),
      .i_ready     (i_ready),
      .o_state     (o_state)
   );

   int           n_cmp = 0;
   int           n_bad = 0;
   int           cyc = 0;
   int           n_xfer = 0;
   logic [7:0]   inv_tab [256];
   logic [127:0] exp_q [$];
   int           acc_q [$];
   logic [127:0] last_out = '0;
   logic         prev_valid = 1'b0;
   logic         prev_hold = 1'b0;
   logic [127:0] prev_state = '0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic fail(input string name);
      n_cmp++;
      n_bad++;
      $display("FAIL %s: event did not happen as required (cycle %0d)", name, cyc);
   endtask

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] r = 8'h00;
      logic [7:0] x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) r ^= x;
         x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
      end
      return r;
   endfunction

   // Forward S-box from field inverse plus affine map, then inverted into a table.
   task automatic build_inv_tab();
      for (int x = 0; x < 256; x++) begin
         logic [7:0] v = 8'h00;
         logic [7:0] s;
         for (int y = 1; y < 256; y++)
            if (gmul(8'(x), 8'(y)) == 8'h01) v = 8'(y);
         for (int i = 0; i < 8; i++)
            s[i] = v[i] ^ v[(i+4)%8] ^ v[(i+5)%8] ^ v[(i+6)%8] ^ v[(i+7)%8] ^ (8'h63 >> i & 8'h01) != 0;
         inv_tab[s] = 8'(x);
      end
   endtask

   function automatic logic [127:0] model(input logic [127:0] st, input logic [127:0] k, input logic l);
      logic [7:0] a [16];
      logic [7:0] b [16];
      logic [7:0] coef [4] = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
      logic [127:0] r;
      for (int i = 0; i < 16; i++) a[i] = st[127-8*i -: 8];
      for (int c = 0; c < 4; c++)
         for (int row = 0; row < 4; row++)
            b[4*c+row] = inv_tab[a[4*((c-row+4)%4)+row]] ^ k[127-8*(4*c+row) -: 8];
      for (int c = 0; c < 4; c++)
         for (int row = 0; row < 4; row++) begin
            logic [7:0] acc = 8'h00;
            for (int j = 0; j < 4; j++)
               acc ^= gmul(b[4*c+(row+j)%4], coef[j]);
            r[127-8*(4*c+row) -: 8] = l ? b[4*c+row] : acc;
         end
      return r;
   endfunction

   always @(negedge clk) begin
      if (rst) begin
         exp_q.delete();
         acc_q.delete();
         prev_valid = 1'b0;
         prev_hold  = 1'b0;
      end else begin
         if (prev_hold) begin
            chk("hold_valid", 128'(o_valid), 128'd1);
            chk("hold_state", o_state, prev_state);
         end
         if (o_valid) begin
            chk("ready_in_hold", 128'(o_ready), 128'd0);
            if (exp_q.size() == 0) fail("spurious_valid");
            else begin
               chk("o_state", o_state, exp_q[0]);
               if (!prev_valid) chk("latency", 128'(cyc), 128'(acc_q[0] + 5));
               if (i_ready) begin
                  $display("xfer %0d: o_state=%h cycle=%0d", n_xfer, o_state, cyc);
                  last_out = o_state;
                  n_xfer++;
                  void'(exp_q.pop_front());
                  void'(acc_q.pop_front());
               end
            end
         end
         prev_valid = o_valid && !i_ready;
         prev_hold  = o_valid && !i_ready;
         prev_state = o_state;
      end
   end

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic send(input logic [127:0] s, input logic [127:0] k, input logic l, output int acc_edge);
      logic ok = 1'b0;
      logic l_eff = l;
      int   waited = 0;
      acc_edge = -1;
`ifdef AES_INV_LAST_ROUND_EN
      tb_last = l;
`else
      l_eff = 1'b0;
`endif
      i_state = s;
      i_round_key = k;
      i_valid = 1'b1;
      while (!ok && waited < 50) begin
         @(negedge clk);
         if (o_ready && !rst) begin
            ok = 1'b1;
            acc_edge = cyc + 1;
            exp_q.push_back(model(s, k, l_eff));
            acc_q.push_back(acc_edge);
            $display("accept: state=%h key=%h last=%0d edge=%0d", s, k, l, acc_edge);
         end
         step();
         waited++;
      end
      if (!ok) fail("accept_timeout");
   endtask

   task automatic wait_idle(input string name);
      int n = 0;
      while (exp_q.size() != 0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (exp_q.size() != 0) fail(name);
      step();
   endtask

   initial begin
      int e0, e1, e2, xf;
      build_inv_tab();
      chk("model_zero", model('0, '0, 1'b0), ALL_52);
      chk("model_c1", model(C1_STATE, C1_KEY, 1'b0), C1_MIX);
      chk("model_c1_last", model(C1_STATE, C1_KEY, 1'b1), C1_LAST);

      repeat (3) step();
      rst = 1'b0;
      @(negedge clk);
      chk("rst_valid", 128'(o_valid), 128'd0);
      chk("rst_state", o_state, 128'd0);
      chk("rst_ready", 128'(o_ready), 128'd1);
      step();

      send('0, '0, 1'b0, e0);
      i_valid = 1'b0;
      wait_idle("zero_timeout");
      chk("zero_vec", last_out, ALL_52);

      send(C1_STATE, C1_KEY, 1'b0, e0);
      i_valid = 1'b0;
      wait_idle("c1_timeout");
      chk("c1_round", last_out, C1_MIX);

`ifdef AES_INV_LAST_ROUND_EN
      send(C1_STATE, C1_KEY, 1'b1, e0);
      i_valid = 1'b0;
      wait_idle("last_timeout");
      chk("c1_last", last_out, C1_LAST);
`endif

      // Reset two cycles into SUB must discard the round entirely.
      xf = n_xfer;
      send(C1_STATE, C1_KEY, 1'b0, e0);
      i_valid = 1'b0;
      step();
      rst = 1'b1;
      repeat (2) step();
      rst = 1'b0;
      @(negedge clk);
      chk("midrst_valid", 128'(o_valid), 128'd0);
      chk("midrst_state", o_state, 128'd0);
      chk("midrst_ready", 128'(o_ready), 128'd1);
      repeat (12) step();
      chk("midrst_no_xfer", 128'(n_xfer), 128'(xf));

      i_ready = 1'b0;
      send({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom}, 1'b0, e0);
      i_valid = 1'b0;
      begin
         int n = 0;
         while (!o_valid && n < 20) begin
            @(negedge clk);
            n++;
         end
         if (!o_valid) fail("bp_valid_timeout");
      end
      for (int i = 0; i < 10; i++) begin
         step();
         i_valid = 1'($urandom_range(0, 1));
         i_state = {$urandom, $urandom, $urandom, $urandom};
      end
      step();
      xf = n_xfer;
      i_valid = 1'b0;
      i_ready = 1'b1;
      wait_idle("bp_release_timeout");
      @(negedge clk);
      chk("bp_one_xfer", 128'(n_xfer), 128'(xf + 1));
      chk("bp_idle_ready", 128'(o_ready), 128'd1);
      chk("bp_idle_valid", 128'(o_valid), 128'd0);
      step();

      xf = n_xfer;
      send({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom}, 1'b0, e0);
      send({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom}, 1'b0, e1);
      send({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom}, 1'b0, e2);
      i_valid = 1'b0;
      wait_idle("b2b_timeout");
      chk("b2b_gap1", 128'(e1 - e0), 128'd7);
      chk("b2b_gap2", 128'(e2 - e1), 128'd7);
      chk("b2b_count", 128'(n_xfer), 128'(xf + 3));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
